// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the six-gate logic array: steps {a,b} through all four
// combinations, checks y against the AND/NAND/OR/NOR/XOR/XNOR table, accumulates failures.
module gate_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       sweeps,
   input  logic [5:0]       y,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic [5:0]       fail_mask,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int                SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_idx;
   logic [7:0]         r_sweep;
   logic [7:0]         r_sweeps;
   logic [SET_W-1:0]   r_settle;
   logic [5:0]         r_fail_mask;
   logic [CNT_W-1:0]   r_err_cnt;
   logic               r_busy;
   logic               r_done;

   logic [5:0]         w_exp;
   logic [5:0]         w_mism;
   logic               w_any_mism;
   logic               w_settle_done;
   logic               w_last_vec;
   logic               w_last_sweep;

   function automatic logic [5:0] expected_y(input logic i_a, input logic i_b);
      return {~(i_a ^ i_b), (i_a ^ i_b), ~(i_a | i_b), (i_a | i_b), ~(i_a & i_b), (i_a & i_b)};
   endfunction

   // The vector index is the operand register, so a/b hold their last value outside a run.
   assign a          = r_idx[1];
   assign b          = r_idx[0];
   assign busy       = r_busy;
   assign done       = r_done;
   assign fail_mask  = r_fail_mask;
   assign err_cnt    = r_err_cnt;

   assign w_exp         = expected_y(r_idx[1], r_idx[0]);
   assign w_mism        = y ^ w_exp;
   assign w_any_mism    = |w_mism;
   assign w_settle_done = (r_settle == SET_LAST);
   assign w_last_vec    = (r_idx == 2'd3);
   assign w_last_sweep  = (r_sweep == (r_sweeps - 8'd1));

   // Next-state decode for the sweep sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_DRIVE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (w_settle_done) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_SAMPLE: begin
            if (w_last_vec && w_last_sweep) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Status flags registered from the next state so they align with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
         r_done <= (w_state_nxt == ST_DONE);
      end
   end

   // Vector/sweep/settle counters and the result accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= 2'd0;
         r_sweep     <= 8'd0;
         r_sweeps    <= 8'd1;
         r_settle    <= '0;
         r_fail_mask <= 6'd0;
         r_err_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sweeps    <= (sweeps == 8'd0) ? 8'd1 : sweeps;
                  r_sweep     <= 8'd0;
                  r_idx       <= 2'd0;
                  r_settle    <= '0;
                  r_fail_mask <= 6'd0;
                  r_err_cnt   <= '0;
               end
            end
            ST_DRIVE: begin
               if (w_settle_done) begin
                  r_settle <= '0;
               end else begin
                  r_settle <= r_settle + SET_W'(1);
               end
            end
            ST_SAMPLE: begin
               r_fail_mask <= r_fail_mask | w_mism;
               // One count per failing vector, pinned at all-ones rather than wrapping.
               if (w_any_mism && (r_err_cnt != CNT_MAX)) begin
                  r_err_cnt <= r_err_cnt + CNT_W'(1);
               end
               if (!w_last_vec) begin
                  r_idx <= r_idx + 2'd1;
               end else if (!w_last_sweep) begin
                  r_idx   <= 2'd0;
                  r_sweep <= r_sweep + 8'd1;
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three instances (S/CNT_W variants) checked every cycle
// against a schedule-based model, plus directed literal checks.
module tb_gate_sweep_ctrl;

   localparam int S_P  [3] = '{1, 1, 3};
   localparam int CMAX [3] = '{255, 3, 255};

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      start_v;
   logic [7:0]      sweeps_v [3];
   logic [5:0]      y_v [3];
   logic [2:0]      a_v, b_v, busy_v, done_v;
   logic [5:0]      fm_v [3];
   logic [7:0]      ec0, ec2;
   logic [1:0]      ec1;
   int              fault_v [3];

   int              n_chk = 0;
   int              n_pass = 0;

   bit              ran [3];
   int              c [3];
   int              n_eff [3];
   int              flt_run [3];

   always #5 clk = ~clk;

   gate_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sweeps(sweeps_v[0]), .y(y_v[0]),
      .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fail_mask(fm_v[0]), .err_cnt(ec0));
   gate_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sweeps(sweeps_v[1]), .y(y_v[1]),
      .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fail_mask(fm_v[1]), .err_cnt(ec1));
   gate_sweep_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sweeps(sweeps_v[2]), .y(y_v[2]),
      .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fail_mask(fm_v[2]), .err_cnt(ec2));

   function automatic logic [5:0] good_y(input logic aa, input logic bb);
      return {~(aa ^ bb), (aa ^ bb), ~(aa | bb), (aa | bb), ~(aa & bb), (aa & bb)};
   endfunction

   // Gate array as seen by the DUT: 0 healthy, 1 NOR stuck-at-0, 2 every output inverted.
   function automatic logic [5:0] array_y(input int f, input logic aa, input logic bb);
      logic [5:0] g;
      g = good_y(aa, bb);
      case (f)
         1:       g[3] = 1'b0;
         2:       g = ~g;
         default: g = g;
      endcase
      return g;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         y_v[i] = array_y(fault_v[i], a_v[i], b_v[i]);
      end
   end

   function automatic int ec_of(input int i);
      case (i)
         0:       return int'(ec0);
         1:       return int'(ec1);
         default: return int'(ec2);
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model bookkeeping: c is the cycle number since the last accepted start (first DRIVE cycle = 1).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            ran[i] <= 1'b0;
            c[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (start_v[i] && (!ran[i] || c[i] > 4 * (S_P[i] + 1) * n_eff[i] + 1)) begin
               ran[i]     <= 1'b1;
               c[i]       <= 1;
               n_eff[i]   <= (sweeps_v[i] == 8'd0) ? 1 : int'(sweeps_v[i]);
               flt_run[i] <= fault_v[i];
            end else if (ran[i]) begin
               c[i] <= c[i] + 1;
            end
         end
      end
   end

   // Expected outputs from the timing schedule: vector k is sampled in cycle (k+1)(S+1).
   task automatic expect_out(input int i, output int ea, output int eb, output int ebusy,
                             output int edone, output int efm, output int eec);
      int s, n, fin, idx, ns;
      logic [5:0] mm;
      ea = 0; eb = 0; ebusy = 0; edone = 0; efm = 0; eec = 0;
      if (ran[i]) begin
         s   = S_P[i];
         n   = n_eff[i];
         fin = 4 * (s + 1) * n;
         if (c[i] <= fin) begin
            idx   = ((c[i] - 1) / (s + 1)) % 4;
            ebusy = 1;
         end else begin
            idx   = 3;
            edone = (c[i] == fin + 1) ? 1 : 0;
         end
         ea = idx / 2;
         eb = idx % 2;
         ns = (c[i] - 1) / (s + 1);
         if (ns > 4 * n) ns = 4 * n;
         for (int k = 0; k < ns; k++) begin
            mm  = array_y(flt_run[i], (k % 4) >= 2, (k % 2) == 1) ^ good_y((k % 4) >= 2, (k % 2) == 1);
            efm = efm | int'(mm);
            if (mm != 6'd0 && eec < CMAX[i]) eec++;
         end
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      int ea, eb, ebusy, edone, efm, eec;
      for (int i = 0; i < 3; i++) begin
         expect_out(i, ea, eb, ebusy, edone, efm, eec);
         chk($sformatf("a[%0d]", i), int'(a_v[i]), ea);
         chk($sformatf("b[%0d]", i), int'(b_v[i]), eb);
         chk($sformatf("busy[%0d]", i), int'(busy_v[i]), ebusy);
         chk($sformatf("done[%0d]", i), int'(done_v[i]), edone);
         chk($sformatf("fail_mask[%0d]", i), int'(fm_v[i]), efm);
         chk($sformatf("err_cnt[%0d]", i), ec_of(i), eec);
      end
   end

   task automatic pulse_start(input int i, input int sw);
      @(posedge clk);
      #1;
      sweeps_v[i] = 8'(sw);
      start_v[i]  = 1'b1;
      @(posedge clk);
      #1;
      start_v[i]  = 1'b0;
   endtask

   task automatic goto_cycle(input int i, input int tgt);
      int n;
      n = 0;
      while (c[i] < tgt && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (c[i] < tgt) chk("goto_cycle_timeout", c[i], tgt);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         sweeps_v[i] = 8'd0;
         fault_v[i]  = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_busy", int'(busy_v), 0);
      chk("reset_ab", int'({a_v[0], b_v[0]}), 0);
      chk("reset_err", int'(ec0), 0);

      // Healthy array, one sweep: operand steps and done timing.
      pulse_start(0, 1);
      for (int v = 0; v < 4; v++) begin
         goto_cycle(0, 1 + 2 * v);
         @(negedge clk);
         chk("ab_step", int'({a_v[0], b_v[0]}), v);
      end
      goto_cycle(0, 9);
      @(negedge clk);
      chk("done_c9", int'(done_v[0]), 1);
      goto_cycle(0, 10);
      @(negedge clk);
      chk("done_gone", int'(done_v[0]), 0);
      chk("clean_mask", int'(fm_v[0]), 0);
      chk("clean_err", int'(ec0), 0);

      // NOR stuck-at-0.
      fault_v[0] = 1;
      pulse_start(0, 1);
      goto_cycle(0, 10);
      @(negedge clk);
      chk("nor_mask", int'(fm_v[0]), 8);
      chk("nor_err", int'(ec0), 1);

      pulse_start(0, 3);
      goto_cycle(0, 25);
      @(negedge clk);
      chk("nor3_done_c25", int'(done_v[0]), 1);
      chk("nor3_err", int'(ec0), 3);

      // sweeps=0 behaves as one sweep and clears the count.
      fault_v[0] = 0;
      pulse_start(0, 0);
      goto_cycle(0, 9);
      @(negedge clk);
      chk("sw0_done_c9", int'(done_v[0]), 1);
      chk("sw0_err", int'(ec0), 0);

      // 2-bit counter saturation with an inverted array.
      fault_v[1] = 2;
      pulse_start(1, 2);
      goto_cycle(1, 18);
      @(negedge clk);
      chk("inv_mask", int'(fm_v[1]), 63);
      chk("inv_err_sat", int'(ec1), 3);

      // Longer settle; a start during the run is ignored.
      pulse_start(2, 1);
      goto_cycle(2, 5);
      start_v[2] = 1'b1;
      @(posedge clk);
      #1;
      start_v[2] = 1'b0;
      @(negedge clk);
      chk("s3_no_restart_ab", int'({a_v[2], b_v[2]}), 1);
      chk("s3_busy", int'(busy_v[2]), 1);
      goto_cycle(2, 17);
      @(negedge clk);
      chk("s3_done_c17", int'(done_v[2]), 1);
      chk("s3_err", int'(ec2), 0);

      // Asynchronous reset mid-run, then a clean run.
      fault_v[0] = 1;
      pulse_start(0, 1);
      goto_cycle(0, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ab", int'({a_v[0], b_v[0]}), 0);
      chk("arst_busy", int'(busy_v[0]), 0);
      chk("arst_mask", int'(fm_v[0]), 0);
      chk("arst_err", int'(ec0), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      fault_v[0] = 0;
      pulse_start(0, 1);
      goto_cycle(0, 9);
      @(negedge clk);
      chk("post_rst_done_c9", int'(done_v[0]), 1);
      chk("post_rst_err", int'(ec0), 0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
